// File: rtl/instr_fetch.sv
// Fetch stage of the multicycle MIPS datapath: owns the PC, fetches over a req/ack port into the IR.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned next-PC redirects to TRAP_PC and sets a sticky misalign flag.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IFETCH_ALIGN_CHECK_EN
  , parameter logic [31:0] TRAP_PC = 32'h0000_0080
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic [31:0] BranchOffset,
  input  logic [25:0] JumpTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Opcode,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
`ifdef IFETCH_ALIGN_CHECK_EN
  , output logic      misalign
`endif
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state, state_nx;
  logic        req_nx, ir_valid_nx;
  logic [31:0] pc_nx, opcode_nx;
  logic [31:0] next_pc_raw, next_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        misalign_nx;
`endif

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Jump beats taken branch; everything else falls through sequentially.
  always_comb begin
    next_pc_raw = pc_plus4;
    if (Jump)                next_pc_raw = {pc_plus4[31:28], JumpTarget, 2'b00};
    else if (Branch && Zero) next_pc_raw = pc_plus4 + (BranchOffset << 2);
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  assign next_pc = next_pc_raw;
`else
  assign next_pc = next_pc_raw & ~32'h0000_0003;
`endif

  // Next-state logic. imem_req is only raised after the first post-reset edge, so a stale ack is dropped.
  always_comb begin
    state_nx    = state;
    req_nx      = imem_req;
    pc_nx       = pc;
    opcode_nx   = Opcode;
    ir_valid_nx = ir_valid;
`ifdef IFETCH_ALIGN_CHECK_EN
    misalign_nx = misalign;
`endif
    case (state)
      FETCH: begin
        if (!imem_req) begin
          req_nx = 1'b1;
        end else if (imem_ack) begin
          opcode_nx   = imem_rdata;
          ir_valid_nx = 1'b1;
          req_nx      = 1'b0;
          state_nx    = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          pc_nx       = next_pc;
          ir_valid_nx = 1'b0;
          req_nx      = 1'b1;
          state_nx    = FETCH;
`ifdef IFETCH_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            pc_nx       = TRAP_PC;
            misalign_nx = 1'b1;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      imem_req <= 1'b0;
      pc       <= RESET_PC;
      Opcode   <= 32'h0;
      ir_valid <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      imem_req <= req_nx;
      pc       <= pc_nx;
      Opcode   <= opcode_nx;
      ir_valid <= ir_valid_nx;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign <= misalign_nx;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: reset, sequential/branch/jump next-PC, ignored inputs, async reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        advance, Branch, Zero, Jump;
  logic [31:0] BranchOffset;
  logic [25:0] JumpTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Opcode;
  logic        ir_valid;
  logic [31:0] pc, pc_plus4;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .advance(advance), .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .BranchOffset(BranchOffset), .JumpTarget(JumpTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Opcode(Opcode), .ir_valid(ir_valid), .pc(pc), .pc_plus4(pc_plus4)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  // Memory responder: waits (bounded) for imem_req, stalls `delay` cycles, then acks for one cycle.
  task automatic do_fetch(input logic [31:0] word, input int delay, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (imem_req) ok = 1'b1;
      else @(negedge clk);
    end
    repeat (delay) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Control pulse: retire with the given branch/jump inputs for exactly one cycle.
  task automatic retire(input logic br, input logic z, input logic j,
                        input logic [31:0] off, input logic [25:0] jt);
    Branch = br; Zero = z; Jump = j; BranchOffset = off; JumpTarget = jt;
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
    checks++; if (Opcode !== 32'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=00000000", Opcode); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ir_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got=%h exp=00000000", imem_addr); end
  endtask

  task automatic test_first_fetch;
    bit ok;
    do_fetch(32'h8C01_0004, 2, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL first_fetch_timeout got=%b exp=1", ok); end
    checks++; if (Opcode !== 32'h8C01_0004) begin errors++; $display("FAIL first_opcode got=%h exp=8c010004", Opcode); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", ir_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got=%b exp=0", imem_req); end
  endtask

  task automatic test_sequential;
    bit ok;
    retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc got=%h exp=00000004", pc); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL seq_valid got=%b exp=0", ir_valid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req got=%b exp=1", imem_req); end
    do_fetch(32'h0000_0020, 0, ok);
    checks++; if (ir_valid !== 1'b1 || !ok) begin errors++; $display("FAIL seq_fetch got=%b exp=1", ir_valid); end
  endtask

  task automatic test_branch;
    bit ok;
    retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    do_fetch(32'h1000_FFFE, 0, ok);
    checks++; if (pc !== 32'h8 || !ok) begin errors++; $display("FAIL br_setup_pc got=%h exp=00000008", pc); end
    retire(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0);
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL br_taken_pc got=%h exp=00000004", pc); end
    do_fetch(32'h0, 1, ok);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    do_fetch(32'h1000_FFFE, 0, ok);
    retire(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 26'h0);
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL br_not_taken_pc got=%h exp=0000000c", pc); end
    do_fetch(32'h0, 0, ok);
  endtask

  task automatic test_jump;
    bit ok;
    retire(1'b1, 1'b1, 1'b0, 32'h0400_0000, 26'h0);
    checks++; if (pc !== 32'h1000_0010) begin errors++; $display("FAIL far_branch_pc got=%h exp=10000010", pc); end
    do_fetch(32'h0800_0040, 0, ok);
    retire(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 26'h000_0040);
    checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL jump_pc got=%h exp=10000100", pc); end
    do_fetch(32'h0, 0, ok);
  endtask

  task automatic test_wrap;
    bit ok;
    retire(1'b1, 1'b1, 1'b0, 32'h3BFF_FFBE, 26'h0);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=fffffffc", pc); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); end
    do_fetch(32'h0, 0, ok);
    retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_seq_pc got=%h exp=00000000", pc); end
  endtask

  task automatic test_ignored;
    bit ok;
    // pc=0, FETCH: advance with Jump must not move pc.
    retire(1'b0, 1'b0, 1'b1, 32'h0, 26'h3FF_FFFF);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL adv_in_fetch_pc got=%h exp=00000000", pc); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL adv_in_fetch_req got=%b exp=1", imem_req); end
    do_fetch(32'hAAAA_5555, 0, ok);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (Opcode !== 32'hAAAA_5555) begin errors++; $display("FAIL ack_in_hold_opcode got=%h exp=aaaa5555", Opcode); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL ack_in_hold_pc got=%h exp=00000000", pc); end
    checks++; if (imem_req !== 1'b0 || ir_valid !== 1'b1) begin errors++; $display("FAIL ack_in_hold_ctl got=%b%b exp=01", imem_req, ir_valid); end
  endtask

  task automatic test_reset_mid_fetch;
    bit ok;
    retire(1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    checks++; if (imem_req !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL pre_rst got=%b/%h exp=1/00000004", imem_req, pc); end
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_rst_req got=%b exp=0", imem_req); end
    checks++; if (Opcode !== 32'h0) begin errors++; $display("FAIL async_rst_opcode got=%h exp=00000000", Opcode); end
    checks++; if (ir_valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL async_rst_state got=%b/%h exp=0/00000000", ir_valid, pc); end
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0 || Opcode !== 32'h0) begin errors++; $display("FAIL late_ack got=%b/%h exp=0/00000000", ir_valid, Opcode); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL restart got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    imem_ack = 1'b0;
    do_fetch(32'h2002_0001, 1, ok);
    checks++; if (Opcode !== 32'h2002_0001 || !ok) begin errors++; $display("FAIL restart_fetch got=%h exp=20020001", Opcode); end
  endtask

  initial begin
    rst = 1'b0; advance = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0;
    BranchOffset = 32'h0; JumpTarget = 26'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
    test_reset;
    test_first_fetch;
    test_sequential;
    test_branch;
    test_jump;
    test_wrap;
    test_ignored;
    test_reset_mid_fetch;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
